aes_req_scheduler: RTL and testbench

AES_REQ_SCHEDULER -- requirements
Module: aes_req_scheduler

---
 rtl/aes_req_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_aes_req_scheduler.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler
// Two-requester round-robin front end for one shared, fully pipelined AES-128
// core. A granted request's plaintext/key is registered onto the core inputs,
// and a {valid, id} tag travels alongside the core pipeline. The tag
// re-appears as a single-cycle response strobe at the moment core_out holds
// the matching ciphertext.
//
// Handshake semantics (both request ports): a transfer happens on every
// rising clk edge where reqN_valid and reqN_ready are both high. reqN_ready
// is combinational from en, both valids and the round-robin pointer, and it
// never depends on reqN_valid of the same port being held. At most one port
// sees ready per cycle. Responses have no backpressure: rspN_valid is high
// for exactly one cycle, and rsp_data is valid only in that cycle.
//
// Timing: a request accepted at edge E drives the core input registers from
// edge E. core_out holds its result after edge E+LATENCY. The tag for that
// request therefore sits in an issue register (edge E), then in tag stage 0
// (edge E+1). It reaches the last of the LATENCY tag stages at edge
// E+LATENCY, which is the response cycle.
module aes_req_scheduler #(
    parameter int LATENCY = 21,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           req0_valid,
    input  logic                           req1_valid,
    output logic                           req0_ready,
    output logic                           req1_ready,
    input  logic [127:0]                   req0_state,
    input  logic [127:0]                   req1_state,
    input  logic [127:0]                   req0_key,
    input  logic [127:0]                   req1_key,
    output logic [127:0]                   core_state,
    output logic [127:0]                   core_key,
    input  logic [127:0]                   core_out,
    output logic                           rsp0_valid,
    output logic                           rsp1_valid,
    output logic [127:0]                   rsp_data,
    output logic [$clog2(LATENCY+1)-1:0]   inflight,
    output logic [CNT_W-1:0]               issued0,
    output logic [CNT_W-1:0]               issued1,
    output logic                           idle
);

    localparam int INF_W = $clog2(LATENCY + 1);

    // Arbitration state: 0 means requester 0 wins a tie, 1 means requester 1.
    logic                 rr_ptr_q, rr_ptr_d;

    // Combinational grant signals.
    logic                 grant0, grant1;
    logic                 hs;
    logic                 hs_id;

    // Registered drive to the core.
    logic [127:0]         core_state_q, core_state_d;
    logic [127:0]         core_key_q, core_key_d;

    // Tag that accompanies the core input registers (loaded on the handshake edge).
    logic                 issue_vld_q, issue_vld_d;
    logic                 issue_id_q, issue_id_d;

    // Tag pipeline, stage 0 first; the last stage lines up with core_out.
    logic [LATENCY-1:0]   tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0]   tag_id_q, tag_id_d;

    // A tag entering the last stage is the edge at which its request counts as returned.
    logic                 ret;

    logic [INF_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     issued0_q, issued0_d;
    logic [CNT_W-1:0]     issued1_q, issued1_d;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && en) begin
            if (req0_valid && (!req1_valid || !rr_ptr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        hs    = grant0 | grant1;
        hs_id = grant1;
    end

    // Pointer moves to the other requester after every transfer, holds otherwise.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = ~hs_id;
        end
    end

    // Core operands switch as a whole block so the core never sees a mix of requesters.
    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (hs) begin
            core_state_d = hs_id ? req1_state : req0_state;
            core_key_d   = hs_id ? req1_key   : req0_key;
        end
    end

    // Issue tag and tag pipeline shift every cycle; bubbles carry valid=0.
    always_comb begin
        issue_vld_d = hs;
        issue_id_d  = hs_id;
        tag_vld_d   = '0;
        tag_id_d    = '0;
        tag_vld_d[0] = issue_vld_q;
        tag_id_d[0]  = issue_id_q;
        for (int k = 1; k < LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
        ret = tag_vld_d[LATENCY-1];
    end

    // Outstanding count: issue and return in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({hs, ret})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Per-requester acceptance counters wrap naturally at 2^CNT_W.
    always_comb begin
        issued0_d = issued0_q + {{(CNT_W-1){1'b0}}, grant0};
        issued1_d = issued1_q + {{(CNT_W-1){1'b0}}, grant1};
    end

    // Arbitration pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Core operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_state_q <= '0;
            core_key_q   <= '0;
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
        end
    end

    // Tag registers; clearing them on reset drops anything still inside the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_vld_q <= 1'b0;
            issue_id_q  <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            issue_id_q  <= issue_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
        end
    end

    // Occupancy and issue counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            issued0_q  <= '0;
            issued1_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            issued0_q  <= issued0_d;
            issued1_q  <= issued1_d;
        end
    end

    // Outputs: strobes are masked during reset because the tags may not be cleared yet.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        core_state = core_state_q;
        core_key   = core_key_q;
        rsp0_valid = !rst && tag_vld_q[LATENCY-1] && !tag_id_q[LATENCY-1];
        rsp1_valid = !rst && tag_vld_q[LATENCY-1] &&  tag_id_q[LATENCY-1];
        rsp_data   = core_out;
        inflight   = inflight_q;
        issued0    = issued0_q;
        issued1    = issued1_q;
        idle       = (inflight_q == '0) && !req0_valid && !req1_valid;
    end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Testbench for aes_req_scheduler: behavioural pipelined AES-128 core model,
// response scoreboard, and one task per scenario.
module tb_aes_req_scheduler;

  localparam int LATENCY = 21;
  localparam int CNT_W   = 16;
  localparam int INF_W   = $clog2(LATENCY + 1);
  localparam int W       = 1 + 128 + 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [127:0]       req0_state, req1_state, req0_key, req1_key;
  logic [127:0]       core_state, core_key, core_out;
  logic               rsp0_valid, rsp1_valid;
  logic [127:0]       rsp_data;
  logic [INF_W-1:0]   inflight;
  logic [CNT_W-1:0]   issued0, issued1;
  logic               idle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int g0     = 0;
  int g1     = 0;

  // scoreboard entry: {id, ciphertext, cycle in which the strobe must appear}
  logic [W-1:0] exp_q[$];

  aes_req_scheduler #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_state(req0_state), .req1_state(req1_state),
    .req0_key(req0_key), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .inflight(inflight), .issued0(issued0), .issued1(issued1), .idle(idle)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k[0] = k[0] ^ sbox_t[k[13]] ^ rc;
      k[1] = k[1] ^ sbox_t[k[14]];
      k[2] = k[2] ^ sbox_t[k[15]];
      k[3] = k[3] ^ sbox_t[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Shared core model: result of the operands held at edge E is on core_out after edge E+LATENCY.
  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    for (int k = LATENCY - 1; k > 0; k--) core_pipe[k] <= core_pipe[k-1];
    core_pipe[0] <= aes128(core_state, core_key);
  end
  assign core_out = core_pipe[LATENCY-1];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         h0, h1;
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    if (h0) begin
      exp_q.push_back({1'b0, aes128(req0_state, req0_key), 32'(cyc + 1 + LATENCY)});
      g0 = g0 + 1;
    end
    if (h1) begin
      exp_q.push_back({1'b1, aes128(req1_state, req1_key), 32'(cyc + 1 + LATENCY)});
      g1 = g1 + 1;
    end
    if (req0_ready || req1_ready) begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL one_grant: got both readys high expected at most one (cycle %0d)", cyc);
      end
    end
    if (!rst) begin
      checks++;
      if (int'(inflight) > LATENCY) begin
        errors++;
        $display("FAIL inflight_bound: got %0d expected <= %0d", inflight, LATENCY);
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      checks++;
      if (rsp0_valid && rsp1_valid) begin
        errors++;
        $display("FAIL rsp_exclusive: got both strobes expected one (cycle %0d)", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got strobe id %0d expected none (cycle %0d)", rsp1_valid, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rsp1_valid !== e[W-1]) begin
          errors++;
          $display("FAIL rsp_id: got %0d expected %0d", rsp1_valid, e[W-1]);
        end
        checks++;
        if (rsp_data !== e[W-2:32]) begin
          errors++;
          $display("FAIL rsp_data: got %h expected %h", rsp_data, e[W-2:32]);
        end
        checks++;
        if (32'(cyc) !== e[31:0]) begin
          errors++;
          $display("FAIL rsp_cycle: got %0d expected %0d", cyc, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req0_state = {$urandom, $urandom, $urandom, $urandom};
    req0_key   = {$urandom, $urandom, $urandom, $urandom};
    req1_state = {$urandom, $urandom, $urandom, $urandom};
    req1_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic apply_reset();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    g0 = 0;
    g1 = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < LATENCY + 10 && (exp_q.size() != 0 || inflight != '0); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending responses expected 0", name, exp_q.size());
    end
    checks++;
    if (inflight !== '0) begin
      errors++;
      $display("FAIL %s_inflight: got %0d expected 0", name, inflight);
    end
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    rand_data();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_rsp: got %b%b expected 00", rsp0_valid, rsp1_valid);
      end
    end
    checks++;
    if (inflight !== '0 || issued0 !== '0 || issued1 !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", inflight, issued0, issued1);
    end
    checks++;
    if (core_state !== '0 || core_key !== '0) begin
      errors++;
      $display("FAIL reset_core: got %h %h expected 0 0", core_state, core_key);
    end
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_high: got %b expected 1", idle);
    end
    tick();
    en = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (idle !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_en_low: got idle %b ready %b expected 0 0", idle, req0_ready);
    end
    tick();
    req0_valid = 1'b0; en = 1'b1;
  endtask

  task automatic test_fips();
    int e;
    bit seen;
    apply_reset();
    req0_state = 128'h00112233445566778899aabbccddeeff;
    req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
    req0_valid = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < LATENCY + 5 && !seen; i++) begin
      @(negedge clk);
      if (rsp0_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fips_timeout: got no rsp0 expected one within %0d cycles", LATENCY + 5);
    end else begin
      if (cyc !== e + LATENCY) begin
        errors++;
        $display("FAIL fips_cycle: got %0d expected %0d", cyc, e + LATENCY);
      end
      checks++;
      if (rsp_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
        errors++;
        $display("FAIL fips_data: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", rsp_data);
      end
    end
    tick();
    wait_drain("fips");
  endtask

  task automatic test_round_robin();
    apply_reset();
    rand_data();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b%b expected %b%b", i, req0_ready, req1_ready,
                 (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      rand_data();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (issued0 !== 16'd5 || issued1 !== 16'd5) begin
      errors++;
      $display("FAIL rr_issued: got %0d/%0d expected 5/5", issued0, issued1);
    end
    wait_drain("rr");
  endtask

  task automatic test_en_pulse();
    logic exp_rdy;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = !(i >= 4 && i < 7);
      rand_data();
      exp_rdy = en;
      @(negedge clk);
      checks++;
      if ((req0_ready | req1_ready) !== exp_rdy) begin
        errors++;
        $display("FAIL en_ready_%0d: got %b expected %b", i, req0_ready | req1_ready, exp_rdy);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
    wait_drain("en");
  endtask

  task automatic test_reset_inflight();
    int strobes;
    req0_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      tick();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inflight !== INF_W'(7)) begin
      errors++;
      $display("FAIL rst_pre_inflight: got %0d expected 7", inflight);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (inflight !== '0 || issued0 !== '0 || issued1 !== '0) begin
      errors++;
      $display("FAIL rst_counts: got %0d/%0d/%0d expected 0/0/0", inflight, issued0, issued1);
    end
    strobes = 0;
    for (int i = 0; i < LATENCY + 5; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL rst_strobes: got %0d expected 0", strobes);
    end
    tick();
    rand_data();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain("rst");
  endtask

  task automatic test_random();
    int  acc;
    bit  h0, h1;
    apply_reset();
    acc = 0; h0 = 1'b0; h1 = 1'b0;
    for (int c = 0; c < 3000 && acc < 100; c++) begin
      if (!req0_valid || h0) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_state = {$urandom, $urandom, $urandom, $urandom};
        req0_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!req1_valid || h1) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        req1_state = {$urandom, $urandom, $urandom, $urandom};
        req1_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      en = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      acc = acc + int'(h0) + int'(h1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
    checks++;
    if (acc != 100) begin
      errors++;
      $display("FAIL random_count: got %0d expected 100", acc);
    end
    wait_drain("random");
    checks++;
    if (int'(issued0) != g0 || int'(issued1) != g1) begin
      errors++;
      $display("FAIL random_issued: got %0d/%0d expected %0d/%0d", issued0, issued1, g0, g1);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    force dut.issued1_q = 16'hffff;
    rand_data();
    req1_valid = 1'b1;
    @(negedge clk);
    release dut.issued1_q;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (issued1 !== 16'h0000 || issued0 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_issued: got %0d/%0d expected 0/0", issued0, issued1);
    end
    wait_drain("wrap");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_state = '0; req1_state = '0; req0_key = '0; req1_key = '0;
    test_reset();
    test_fips();
    test_round_robin();
    test_en_pulse();
    test_reset_inflight();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
